// File: rtl/program_loader.sv
// program_loader
//   Writer side of the program-memory interface. Takes a byte stream over a
//   valid/ready handshake, pairs bytes into 16-bit little-endian instructions
//   and writes them to program memory from address 0 upwards. The CPU core is
//   held in reset for the whole load and released only after a complete load.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active low
//   start       one-cycle pulse that begins a load (ignored while busy)
//   length      number of instructions to load (1..2**ADDR_W), sampled on start
//   byte_valid  byte_data carries a stream byte
//   byte_data   stream byte
//   byte_ready  loader takes a byte this cycle
//   pm_we       program memory write enable (one cycle per instruction)
//   pm_addr     program memory write address
//   pm_wdata    instruction being written
//   cpu_hold    active-high reset request to the CPU core
//   busy        load in progress
//   done        sticky: last load completed
//   error       sticky: last load timed out or was rejected
module program_loader #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W:0]    length,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               pm_we,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic [INSTR_W-1:0] pm_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic [TO_W-1:0]    tcnt_q, tcnt_d;
  logic               first_q, first_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               hold_q, hold_d;
  logic               last_word;
  logic               timed_out;

  // pm_addr doubles as the word counter, so the last word is the one whose
  // address is length-1.
  assign last_word = (({1'b0, addr_q} + (ADDR_W+1)'(1)) == len_q);

  // The idle cycle that would bring the counter to TIMEOUT aborts instead.
  assign timed_out = (tcnt_q == TO_W'(TIMEOUT - 1));

  // State register and datapath registers; everything returns to zero on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tcnt_q  <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tcnt_q  <= tcnt_d;
      first_q <= first_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state and handshake/write strobes.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tcnt_d     = tcnt_q;
    first_d    = first_q;
    done_d     = done_q;
    error_d    = error_q;
    hold_d     = hold_q;
    byte_ready = 1'b0;
    pm_we      = 1'b0;
    busy       = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          if (length == '0 || int'(length) > DEPTH) begin
            state_d = ERROR;
            error_d = 1'b1;
            done_d  = 1'b0;
            hold_d  = 1'b0;
          end else begin
            state_d = LOW;
            len_d   = length;
            done_d  = 1'b0;
            error_d = 1'b0;
            hold_d  = 1'b1;
            addr_d  = '0;
            tcnt_d  = '0;
            first_d = 1'b1;
          end
        end
      end

      LOW: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          wdata_d[7:0] = byte_data;
          tcnt_d       = '0;
          first_d      = 1'b0;
          state_d      = HIGH;
        end else if (!first_q) begin
          // The host may take as long as it likes to send the very first
          // byte; only gaps inside the stream are timed.
          if (timed_out) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TO_W'(1);
          end
        end
      end

      HIGH: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          wdata_d[INSTR_W-1:8] = byte_data;
          tcnt_d               = '0;
          state_d              = WRITE;
        end else if (timed_out) begin
          // cpu_hold is left set so a half-loaded program never runs.
          state_d = ERROR;
          error_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end

      WRITE: begin
        pm_we = 1'b1;
        busy  = 1'b1;
        if (last_word) begin
          state_d = DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          tcnt_d  = '0;
          state_d = LOW;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign pm_addr  = addr_q;
  assign pm_wdata = wdata_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the program-memory interface: receives a byte stream over a valid/ready handshake.
- Assembles pairs of bytes into 16-bit instructions and writes them sequentially into program memory, starting at address 0.
- Holds the CPU core (program counter, accumulator) in reset while loading, then releases it so execution starts from address 0.

Parameters:
- ADDR_W, 5, program memory address width; 32 words.
- INSTR_W, 16, instruction width; fixed at two bytes.
- TIMEOUT, 255, maximum idle cycles allowed between bytes of one load before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load.
- length  in  6  number of instructions to load, 1..32; sampled when start is accepted.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- pm_we  out  1  program memory write enable.
- pm_addr  out  5  program memory write address.
- pm_wdata  out  16  instruction to write.
- cpu_hold  out  1  active-high reset request to the CPU core.
- busy  out  1  load in progress.
- done  out  1  sticky: last load completed.
- error  out  1  sticky: last load aborted or rejected.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; byte_ready, pm_we, cpu_hold, busy, done and error are all 0; pm_addr and pm_wdata are 0; word counter and timeout counter are 0.
- States: IDLE, LOW, HIGH, WRITE, DONE, ERROR.
- IDLE, DONE, ERROR: on start=1:
  - If length is 0 or greater than 32: go to ERROR, set error=1, clear done, cpu_hold=0.
  - Otherwise: latch length, clear done and error, set busy=1 and cpu_hold=1, set pm_addr=0, go to LOW.
- start=1 while busy=1 is ignored.
- LOW: byte_ready=1. A byte is transferred when byte_valid and byte_ready are both 1 in the same cycle. On transfer, the byte becomes pm_wdata[7:0] and the state goes to HIGH.
- HIGH: byte_ready=1. On transfer, the byte becomes pm_wdata[15:8] and the state goes to WRITE. Byte order is little-endian: low byte first.
- WRITE: byte_ready=0; pm_we=1 for exactly this one cycle, with pm_addr and pm_wdata stable.
  - If this is the last word: go to DONE.
  - Otherwise: pm_addr increments by 1 and the state goes to LOW.
- Throughput: 3 cycles per instruction minimum (LOW, HIGH, WRITE).
- pm_we is never asserted outside WRITE.
- Timeout counter: clears on every transfer and on entry to LOW. It increments each cycle in LOW/HIGH without a transfer, except in LOW before the first byte of the load.
  - On reaching TIMEOUT: go to ERROR, error=1, busy=0, cpu_hold stays 1 so a partially loaded program never runs.
  - Words already written remain in memory.
- DONE: busy=0, done=1, cpu_hold=0; the CPU restarts at address 0 on the next cycle.
- ERROR: busy=0, byte_ready=0, error=1. cpu_hold stays 1 if entered by timeout and 0 if entered by a rejected length. Leave ERROR only via start or reset.
- Word counter wrap: pm_addr never wraps within a load, because length is at most 32. The last write goes to address length-1.
- Reset mid-load: the load is abandoned immediately and all outputs return to reset values; cpu_hold drops to 0. Memory contents are whatever was written so far.
- byte_data is ignored whenever byte_ready=0.

Test Plan:
- Reset, then start with length=2 and bytes 0x34,0x12,0x78,0x56 driven back-to-back -> pm_we pulses at addr 0 data 0x1234 and addr 1 data 0x5678; done=1, cpu_hold=0, busy=0; 6 cycles from first byte to last write.
- length=32, random byte_valid gaps shorter than TIMEOUT -> 32 writes at addresses 0..31 in order with correct data; no extra pm_we; done=1.
- start with length=0, and separately length=40 -> error=1, no pm_we, cpu_hold=0, state accepts a following valid start.
- length=3, stop driving after 3 bytes -> after 255 idle cycles error=1, cpu_hold=1, exactly one write (addr 0) observed; a new start with length=1 then loads and clears error.
- Assert start again mid-load (length=4, after 2 words) -> ignored, load completes with 4 writes. Then drive rst=0 mid-load of a second transfer -> all outputs are 0 on the next cycle.
- byte_valid held high during WRITE cycles -> no byte is consumed in WRITE; the byte is accepted in the following LOW cycle, and data is not duplicated or skipped.
